pump_cmd_panel: RTL

//  Front-panel command issuer: the source side of the pump controller command interface.

---
 rtl/pump_cmd_panel.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/pump_cmd_panel.sv
// Front-panel command issuer for the pump controller: debounced buttons, selection
// registers, run-button hold timing and a single-slot command FSM with frozen selects.
module pump_cmd_panel #(
    parameter int CLOCK_FREQ    = 1_000_000,
    parameter int DEBOUNCE_MS   = 20,
    parameter int LONG_PRESS_MS = 1000,
    parameter int GUARD_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_frag,
    input  logic       btn_timer,
    input  logic       btn_run,
    input  logic       btn_manual,
    output logic [1:0] fragrance_select,
    output logic [1:0] timer_select,
    output logic       pump_on,
    output logic       pump_off,
    output logic       manual_on,
    output logic [2:0] run_status,
    output logic       busy
);
    localparam int DEB    = CLOCK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int LONG   = CLOCK_FREQ / 1000 * LONG_PRESS_MS;
    localparam int DEB_W  = $clog2(DEB + 1);
    localparam int LONG_W = $clog2(LONG + 1);
    localparam int GRD_W  = $clog2(GUARD_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB - 1);
    localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
    localparam logic [DEB_W-1:0]  DEB_ZERO  = DEB_W'(0);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG - 1);
    localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG);
    localparam logic [LONG_W-1:0] LONG_ONE  = LONG_W'(1);
    localparam logic [LONG_W-1:0] LONG_ZERO = LONG_W'(0);
    localparam logic [GRD_W-1:0]  GRD_LAST  = GRD_W'(GUARD_CYCLES - 1);
    localparam logic [GRD_W-1:0]  GRD_ONE   = GRD_W'(1);
    localparam logic [GRD_W-1:0]  GRD_ZERO  = GRD_W'(0);

    localparam int B_FRAG  = 0;
    localparam int B_TIMER = 1;
    localparam int B_RUN   = 2;
    localparam int B_MAN   = 3;

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, GUARD} state_t;
    typedef enum logic [1:0] {CMD_NONE, CMD_LONG, CMD_SHORT, CMD_MAN} cmd_t;

    function automatic logic [1:0] next_sel(input logic [1:0] sel);
        case (sel)
            2'd0:    next_sel = 2'd1;
            2'd1:    next_sel = 2'd2;
            default: next_sel = 2'd0;
        endcase
    endfunction

    function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
        case (sel)
            2'd0:    sel_onehot = 3'b001;
            2'd1:    sel_onehot = 3'b010;
            2'd2:    sel_onehot = 3'b100;
            default: sel_onehot = 3'b000;
        endcase
    endfunction

    logic [3:0]        raw_s;
    logic [3:0]        sync1_r, sync2_r, deb_r, rise_r;
    logic              fall_run_r;
    logic [DEB_W-1:0]  deb_cnt_r [4];
    logic              held_r, long_r, short_s;
    logic [LONG_W-1:0] hold_cnt_r;
    cmd_t              new_cmd_s, slot_r, slot_nxt_s;
    state_t            state_r, state_nxt_s;
    logic [1:0]        frag_r, frag_nxt_s, timer_r, timer_nxt_s;
    logic              frag_pend_r, frag_pend_nxt_s, timer_pend_r, timer_pend_nxt_s;
    logic [GRD_W-1:0]  guard_cnt_r, guard_nxt_s;
    logic [2:0]        run_status_r, rs_nxt_s;
    logic              on_r, off_r, man_r, busy_r;
    logic              on_nxt_s, off_nxt_s, man_nxt_s;

    assign raw_s = {btn_manual, btn_run, btn_timer, btn_frag};

    // Two-flop synchronizers and per-button debounce counters with edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r    <= 4'b0000;
            sync2_r    <= 4'b0000;
            deb_r      <= 4'b0000;
            rise_r     <= 4'b0000;
            fall_run_r <= 1'b0;
            for (int i = 0; i < 4; i++) deb_cnt_r[i] <= DEB_ZERO;
        end else begin
            sync1_r    <= raw_s;
            sync2_r    <= sync1_r;
            rise_r     <= 4'b0000;
            fall_run_r <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (sync2_r[i] == deb_r[i]) begin
                    deb_cnt_r[i] <= DEB_ZERO;
                end else if (deb_cnt_r[i] == DEB_LAST) begin
                    deb_cnt_r[i] <= DEB_ZERO;
                    deb_r[i]     <= sync2_r[i];
                    rise_r[i]    <= sync2_r[i];
                    if (i == B_RUN) fall_run_r <= ~sync2_r[i];
                end else begin
                    deb_cnt_r[i] <= deb_cnt_r[i] + DEB_ONE;
                end
            end
        end
    end

    // Run-button hold timer; the long-press event fires once as the count reaches LONG.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_r     <= 1'b0;
            hold_cnt_r <= LONG_ZERO;
            long_r     <= 1'b0;
        end else begin
            long_r <= held_r & ~fall_run_r & (hold_cnt_r == LONG_LAST);
            if (rise_r[B_RUN]) begin
                held_r     <= 1'b1;
                hold_cnt_r <= LONG_ONE;
            end else if (fall_run_r) begin
                held_r     <= 1'b0;
            end else if (held_r && hold_cnt_r != LONG_MAX) begin
                hold_cnt_r <= hold_cnt_r + LONG_ONE;
            end else begin
                hold_cnt_r <= hold_cnt_r;
            end
        end
    end

    assign short_s = fall_run_r & held_r & (hold_cnt_r < LONG_MAX);

    // Same-cycle command arbitration: long-off beats short-run beats manual.
    always_comb begin
        new_cmd_s = CMD_NONE;
        if (long_r) begin
            new_cmd_s = CMD_LONG;
        end else if (short_s) begin
            new_cmd_s = CMD_SHORT;
        end else if (rise_r[B_MAN]) begin
            new_cmd_s = CMD_MAN;
        end else begin
            new_cmd_s = CMD_NONE;
        end
    end

    // Command FSM next state, selection updates and next pulse/run_status values.
    always_comb begin
        state_nxt_s      = state_r;
        slot_nxt_s       = slot_r;
        frag_nxt_s       = frag_r;
        timer_nxt_s      = timer_r;
        frag_pend_nxt_s  = frag_pend_r;
        timer_pend_nxt_s = timer_pend_r;
        guard_nxt_s      = guard_cnt_r;
        rs_nxt_s         = run_status_r;
        on_nxt_s         = 1'b0;
        off_nxt_s        = 1'b0;
        man_nxt_s        = 1'b0;
        if (slot_r == CMD_NONE) begin
            slot_nxt_s = new_cmd_s;
        end else begin
            slot_nxt_s = slot_r;
        end
        case (state_r)
            IDLE: begin
                if (frag_pend_r || rise_r[B_FRAG]) begin
                    frag_nxt_s = next_sel(frag_r);
                end else begin
                    frag_nxt_s = frag_r;
                end
                if (timer_pend_r || rise_r[B_TIMER]) begin
                    timer_nxt_s = next_sel(timer_r);
                end else begin
                    timer_nxt_s = timer_r;
                end
                // A press coinciding with a pending apply is kept for the next idle cycle.
                frag_pend_nxt_s  = frag_pend_r & rise_r[B_FRAG];
                timer_pend_nxt_s = timer_pend_r & rise_r[B_TIMER];
                if (slot_nxt_s != CMD_NONE) begin
                    state_nxt_s = SETUP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SETUP: begin
                frag_pend_nxt_s  = frag_pend_r | rise_r[B_FRAG];
                timer_pend_nxt_s = timer_pend_r | rise_r[B_TIMER];
                state_nxt_s      = PULSE;
                case (slot_r)
                    CMD_LONG: begin
                        off_nxt_s = 1'b1;
                        rs_nxt_s  = 3'b000;
                    end
                    CMD_SHORT: begin
                        if (|(run_status_r & sel_onehot(frag_r))) begin
                            off_nxt_s = 1'b1;
                            rs_nxt_s  = 3'b000;
                        end else begin
                            on_nxt_s = 1'b1;
                            rs_nxt_s = run_status_r | sel_onehot(frag_r);
                        end
                    end
                    CMD_MAN: man_nxt_s = 1'b1;
                    default: state_nxt_s = IDLE;
                endcase
            end
            PULSE: begin
                frag_pend_nxt_s  = frag_pend_r | rise_r[B_FRAG];
                timer_pend_nxt_s = timer_pend_r | rise_r[B_TIMER];
                slot_nxt_s       = CMD_NONE;
                guard_nxt_s      = GRD_ZERO;
                state_nxt_s      = GUARD;
            end
            GUARD: begin
                frag_pend_nxt_s  = frag_pend_r | rise_r[B_FRAG];
                timer_pend_nxt_s = timer_pend_r | rise_r[B_TIMER];
                if (guard_cnt_r == GRD_LAST) begin
                    state_nxt_s = IDLE;
                end else begin
                    guard_nxt_s = guard_cnt_r + GRD_ONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, selection and registered output updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            slot_r       <= CMD_NONE;
            frag_r       <= 2'd0;
            timer_r      <= 2'd0;
            frag_pend_r  <= 1'b0;
            timer_pend_r <= 1'b0;
            guard_cnt_r  <= GRD_ZERO;
            run_status_r <= 3'b000;
            on_r         <= 1'b0;
            off_r        <= 1'b0;
            man_r        <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            slot_r       <= slot_nxt_s;
            frag_r       <= frag_nxt_s;
            timer_r      <= timer_nxt_s;
            frag_pend_r  <= frag_pend_nxt_s;
            timer_pend_r <= timer_pend_nxt_s;
            guard_cnt_r  <= guard_nxt_s;
            run_status_r <= rs_nxt_s;
            on_r         <= on_nxt_s;
            off_r        <= off_nxt_s;
            man_r        <= man_nxt_s;
            busy_r       <= (state_nxt_s != IDLE);
        end
    end

    assign fragrance_select = frag_r;
    assign timer_select     = timer_r;
    assign pump_on          = on_r;
    assign pump_off         = off_r;
    assign manual_on        = man_r;
    assign run_status       = run_status_r;
    assign busy             = busy_r;
endmodule
